// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//
// Issue/sequencing stage in front of the RV32M multiplier. Accepts one
// MUL/MULH/MULHSU/MULHU request at a time and decodes funct3 into the
// multiplier ctrl. It then holds the operands and ctrl frozen for LATENCY
// rising edges. After that it captures the multiplier result and presents it,
// with its destination tag, to writeback until the response handshake.
//
// The multiplier applies ctrl combinationally at both its input
// sign-extension and its output half-select. For that reason mul_a, mul_b and
// mul_ctrl only change on a request accept.
//
// Parameters
//   LATENCY : rising edges from stable multiplier inputs to a valid mul_y (>=1)
//   RD_W    : destination register tag width
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   req_valid/req_ready   : request handshake from execute
//   req_funct3            : RV32M funct3 (bit 2 ignored)
//   req_a, req_b, req_rd  : rs1, rs2 and destination tag
//   flush                 : pipeline kill, highest priority
//   mul_a, mul_b, mul_ctrl: registered multiplier inputs
//                           ctrl[0] a signed, ctrl[1] b signed, ctrl[2] high word
//   mul_y                 : multiplier result
//   rsp_valid/rsp_ready   : response handshake to writeback
//   rsp_data, rsp_rd      : captured result and tag
//   busy                  : an operation is in flight or waiting for writeback
// -----------------------------------------------------------------------------
module mul_sequencer #(
    parameter int LATENCY = 4,
    parameter int RD_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    input  logic [RD_W-1:0] req_rd,
    input  logic            flush,
    output logic [31:0]     mul_a,
    output logic [31:0]     mul_b,
    output logic [2:0]      mul_ctrl,
    input  logic [31:0]     mul_y,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic [RD_W-1:0] rsp_rd,
    output logic            busy
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [31:0]      mul_a_q,     mul_a_d;
    logic [31:0]      mul_b_q,     mul_b_d;
    logic [2:0]       mul_ctrl_q,  mul_ctrl_d;
    logic [RD_W-1:0]  rd_q,        rd_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q,  rsp_data_d;
    logic [RD_W-1:0]  rsp_rd_q,    rsp_rd_d;
    logic             busy_q,      busy_d;

    logic             req_ready_s;
    logic             accept_s;

    // funct3 -> multiplier ctrl. Bit 2 of funct3 is a don't-care, so each
    // ctrl value covers a pair of funct3 codes.
    function automatic logic [2:0] decode_ctrl(input logic [2:0] funct3);
        logic [2:0] ctrl;
        case (funct3)
            3'b000, 3'b100: ctrl = 3'b000;  // MUL    : low word
            3'b001, 3'b101: ctrl = 3'b111;  // MULH   : s x s, high word
            3'b010, 3'b110: ctrl = 3'b101;  // MULHSU : s x u, high word
            3'b011, 3'b111: ctrl = 3'b100;  // MULHU  : u x u, high word
            default:        ctrl = 3'b000;
        endcase
        return ctrl;
    endfunction

    // Request acceptance: IDLE always, DONE only when the pending response
    // retires in the same cycle. Held low by flush and while in reset.
    always_comb begin
        req_ready_s = 1'b0;
        if (!rst_n || flush) begin
            req_ready_s = 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  req_ready_s = 1'b1;
                S_DONE:  req_ready_s = rsp_ready;
                default: req_ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s = req_valid && req_ready_s;

    // Next-state logic for the sequencer and all registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_ctrl_d  = mul_ctrl_q;
        rd_d        = rd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_rd_d    = rsp_rd_q;
        busy_d      = busy_q;

        if (flush) begin
            // Kill whatever is in flight. The multiplier inputs keep their
            // values, because they only ever change on accept.
            state_d     = S_IDLE;
            cnt_d       = '0;
            rsp_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else if (accept_s) begin
            // Covers both the IDLE accept and the back-to-back accept in
            // DONE. The latter implies the old response retires this cycle.
            state_d     = S_WAIT;
            cnt_d       = CNT_W'(LATENCY);
            mul_a_d     = req_a;
            mul_b_d     = req_b;
            mul_ctrl_d  = decode_ctrl(req_funct3);
            rd_d        = req_rd;
            rsp_valid_d = 1'b0;
            busy_d      = 1'b1;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        // Inputs have now been stable for LATENCY edges.
                        state_d     = S_DONE;
                        cnt_d       = '0;
                        rsp_data_d  = mul_y;
                        rsp_rd_d    = rd_q;
                        rsp_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state_d     = S_IDLE;
                        rsp_valid_d = 1'b0;
                        busy_d      = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mul_a_q     <= 32'd0;
            mul_b_q     <= 32'd0;
            mul_ctrl_q  <= 3'b000;
            rd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_rd_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_ctrl_q  <= mul_ctrl_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_s;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_ctrl  = mul_ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
//
// Two sequencers sit in this bench, one with LATENCY=1 and one with
// LATENCY=4. Each is paired with a behavioural multiplier. That multiplier
// returns a corrupted value whenever its inputs have not been stable for
// LATENCY edges, so it stands in for X in a two-state simulator.
//
// Directed scenarios run on the LATENCY=4 instance. After them, a randomized
// phase drives both instances every cycle. That phase is checked against a
// transaction-level model: a pending op, the edges since it was accepted, and
// the result derived from funct3 arithmetic.
// -----------------------------------------------------------------------------
module tb_mul_sequencer;

    localparam int RD_W   = 5;
    localparam int D      = 1;       // LATENCY=4 instance used for directed tests
    localparam int N_RAND = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            req_valid  [2];
    logic            req_ready  [2];
    logic [2:0]      req_funct3 [2];
    logic [31:0]     req_a      [2];
    logic [31:0]     req_b      [2];
    logic [RD_W-1:0] req_rd     [2];
    logic            flush      [2];
    logic [31:0]     mul_a      [2];
    logic [31:0]     mul_b      [2];
    logic [2:0]      mul_ctrl   [2];
    logic            rsp_valid  [2];
    logic            rsp_ready  [2];
    logic [31:0]     rsp_data   [2];
    logic [RD_W-1:0] rsp_rd     [2];
    logic            busy       [2];

    int n_chk  = 0;
    int n_fail = 0;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural result of an RV32M multiply, straight from the ISA rules.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        case (f3[1:0])
            2'b00:   begin p = ua * ub;          return p[31:0];  end
            2'b01:   begin p = sa * sb;          return p[63:32]; end
            2'b10:   begin p = sa * $signed(ub); return p[63:32]; end
            default: begin p = ua * ub;          return p[63:32]; end
        endcase
    endfunction

    // What the multiplier computes for a given ctrl word.
    function automatic logic [31:0] mult_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl);
        logic [63:0] ea, eb, p;
        ea = ctrl[0] ? {{32{a[31]}}, a} : {32'd0, a};
        eb = ctrl[1] ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return ctrl[2] ? p[63:32] : p[31:0];
    endfunction

    // Expected ctrl for a funct3 code.
    function automatic logic [2:0] exp_ctrl(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'b000;
            2'b01:   return 3'b111;
            2'b10:   return 3'b101;
            default: return 3'b100;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 4;
        logic [31:0] my_s;
        logic [66:0] cur_s;
        logic [66:0] prev_q;
        int          age_q;
        int          stable_s;

        mul_sequencer #(.LATENCY(LAT), .RD_W(RD_W)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_funct3 (req_funct3[g]),
            .req_a      (req_a[g]),
            .req_b      (req_b[g]),
            .req_rd     (req_rd[g]),
            .flush      (flush[g]),
            .mul_a      (mul_a[g]),
            .mul_b      (mul_b[g]),
            .mul_ctrl   (mul_ctrl[g]),
            .mul_y      (my_s),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_data   (rsp_data[g]),
            .rsp_rd     (rsp_rd[g]),
            .busy       (busy[g])
        );

        assign cur_s = {mul_a[g], mul_b[g], mul_ctrl[g]};

        // Count the edges for which the multiplier inputs have been unchanged.
        always @(posedge clk) begin
            if (cur_s == prev_q) age_q <= age_q + 1;
            else                 age_q <= 1;
            prev_q <= cur_s;
        end

        // The result is only trustworthy once the upcoming edge is the
        // LAT-th edge with stable inputs. Otherwise return garbage.
        always_comb begin
            stable_s = (cur_s == prev_q) ? age_q + 1 : 1;
            my_s     = mult_model(mul_a[g], mul_b[g], mul_ctrl[g]);
            if (stable_s < LAT) my_s = ~my_s;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until rsp_valid, checking that the operands stay frozen.
    task automatic wait_rsp(input logic [31:0] a, input logic [31:0] b, output int n);
        n = 0;
        while (rsp_valid[D] !== 1'b1 && n < 20) begin
            check_eq("hold_mul_a", 64'(mul_a[D]), 64'(a));
            check_eq("hold_mul_b", 64'(mul_b[D]), 64'(b));
            tick();
            n++;
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [RD_W-1:0] rd, output int n);
        req_valid[D]  = 1'b1;
        req_funct3[D] = f3;
        req_a[D]      = a;
        req_b[D]      = b;
        req_rd[D]     = rd;
        tick();
        req_valid[D] = 1'b0;
        wait_rsp(a, b, n);
    endtask

    logic [2:0]  f3_tab   [4];
    logic [2:0]  ctrl_tab [4];
    logic [31:0] dat_tab  [4];

    logic            pend     [2];
    int              edges    [2];
    logic [31:0]     exp_data [2];
    logic [RD_W-1:0] exp_rd   [2];
    logic [31:0]     last_a   [2];
    logic [31:0]     last_b   [2];
    logic [2:0]      last_f3  [2];

    initial begin
        int  lat;
        logic seen;

        f3_tab   = '{3'b000, 3'b001, 3'b011, 3'b010};
        ctrl_tab = '{3'b000, 3'b111, 3'b100, 3'b101};
        dat_tab  = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_funct3[k] = 3'b000; req_a[k] = 32'd0; req_b[k] = 32'd0;
            req_rd[k] = '0; flush[k] = 1'b0; rsp_ready[k] = 1'b0;
        end

        // ---- reset values, with a request offered during reset ----
        #12;
        req_valid[D] = 1'b1;
        #1;
        check_eq("rst_req_ready", 64'(req_ready[D]), 64'(1'b0));
        check_eq("rst_mul_a",     64'(mul_a[D]),     64'(32'd0));
        check_eq("rst_mul_ctrl",  64'(mul_ctrl[D]),  64'(3'b000));
        check_eq("rst_rsp_valid", 64'(rsp_valid[D]), 64'(1'b0));
        check_eq("rst_rsp_data",  64'(rsp_data[D]),  64'(32'd0));
        check_eq("rst_busy",      64'(busy[D]),      64'(1'b0));
        req_valid[D] = 1'b0;
        rst_n = 1'b1;
        tick();
        rsp_ready[D] = 1'b1;

        // ---- all four funct3 decodes on 0xFFFFFFFF x 0xFFFFFFFF ----
        for (int i = 0; i < 4; i++) begin
            run_op(f3_tab[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, RD_W'(i + 1), lat);
            check_eq("t1_latency",  64'(lat),          64'(4));
            check_eq("t1_mul_ctrl", 64'(mul_ctrl[D]),  64'(ctrl_tab[i]));
            check_eq("t1_rsp_data", 64'(rsp_data[D]),  64'(dat_tab[i]));
            check_eq("t1_rsp_rd",   64'(rsp_rd[D]),    64'(RD_W'(i + 1)));
            tick();
            check_eq("t1_retired",  64'(rsp_valid[D]), 64'(1'b0));
        end

        // ---- MULH of two most-negative values ----
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd7, lat);
        check_eq("t2_latency",  64'(lat),         64'(4));
        check_eq("t2_rsp_data", 64'(rsp_data[D]), 64'(32'h4000_0000));
        check_eq("t2_rsp_rd",   64'(rsp_rd[D]),   64'(5'd7));
        check_eq("t2_mul_ctrl", 64'(mul_ctrl[D]), 64'(3'b111));
        tick();

        // ---- writeback backpressure, then back-to-back accept ----
        rsp_ready[D] = 1'b0;
        run_op(3'b000, 32'd3, 32'd5, 5'd3, lat);
        check_eq("t3_latency", 64'(lat), 64'(4));
        req_valid[D] = 1'b1; req_funct3[D] = 3'b011; req_a[D] = 32'hFFFF_FFFF;
        req_b[D] = 32'd2; req_rd[D] = 5'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("t3_hold_req_ready", 64'(req_ready[D]), 64'(1'b0));
            check_eq("t3_hold_rsp_valid", 64'(rsp_valid[D]), 64'(1'b1));
            check_eq("t3_hold_rsp_data",  64'(rsp_data[D]),  64'(32'd15));
            check_eq("t3_hold_rsp_rd",    64'(rsp_rd[D]),    64'(5'd3));
            tick();
        end
        rsp_ready[D] = 1'b1;
        #1;
        check_eq("t3_b2b_req_ready", 64'(req_ready[D]), 64'(1'b1));
        tick();
        req_valid[D] = 1'b0;
        check_eq("t3_b2b_rsp_dropped", 64'(rsp_valid[D]), 64'(1'b0));
        check_eq("t3_b2b_busy",        64'(busy[D]),      64'(1'b1));
        check_eq("t3_b2b_mul_ctrl",    64'(mul_ctrl[D]),  64'(3'b100));
        wait_rsp(32'hFFFF_FFFF, 32'd2, lat);
        check_eq("t3_b2b_latency",  64'(lat),         64'(4));
        check_eq("t3_b2b_rsp_data", 64'(rsp_data[D]), 64'(32'd1));
        check_eq("t3_b2b_rsp_rd",   64'(rsp_rd[D]),   64'(5'd9));
        tick();

        // ---- flush in the second WAIT cycle ----
        req_valid[D] = 1'b1; req_funct3[D] = 3'b000; req_a[D] = 32'd7; req_b[D] = 32'd6; req_rd[D] = 5'd1;
        tick();
        req_valid[D] = 1'b0;
        tick();
        flush[D] = 1'b1;
        #1;
        check_eq("t4_wait_req_ready", 64'(req_ready[D]), 64'(1'b0));
        tick();
        flush[D] = 1'b0;
        check_eq("t4_wait_idle",  64'(busy[D]),  64'(1'b0));
        check_eq("t4_wait_mul_a", 64'(mul_a[D]), 64'(32'd7));
        seen = 1'b0;
        repeat (6) begin
            if (rsp_valid[D] === 1'b1) seen = 1'b1;
            tick();
        end
        check_eq("t4_wait_no_rsp", 64'(seen), 64'(1'b0));

        // ---- flush in DONE ----
        rsp_ready[D] = 1'b0;
        run_op(3'b000, 32'd9, 32'd9, 5'd2, lat);
        check_eq("t4_done_latency", 64'(lat), 64'(4));
        flush[D] = 1'b1;
        #1;
        check_eq("t4_done_req_ready", 64'(req_ready[D]), 64'(1'b0));
        tick();
        flush[D] = 1'b0;
        check_eq("t4_done_rsp_valid", 64'(rsp_valid[D]), 64'(1'b0));
        check_eq("t4_done_idle",      64'(busy[D]),      64'(1'b0));

        // ---- flush in IDLE with a request offered ----
        rsp_ready[D] = 1'b1;
        req_valid[D] = 1'b1; req_a[D] = 32'd11; req_b[D] = 32'd11;
        flush[D] = 1'b1;
        #1;
        check_eq("t4_idle_req_ready", 64'(req_ready[D]), 64'(1'b0));
        tick();
        req_valid[D] = 1'b0;
        flush[D] = 1'b0;
        check_eq("t4_idle_not_busy", 64'(busy[D]),  64'(1'b0));
        check_eq("t4_idle_mul_a",    64'(mul_a[D]), 64'(32'd9));
        seen = 1'b0;
        repeat (6) begin
            if (rsp_valid[D] === 1'b1) seen = 1'b1;
            tick();
        end
        check_eq("t4_idle_no_rsp", 64'(seen), 64'(1'b0));

        // ---- asynchronous reset in the middle of WAIT ----
        req_valid[D] = 1'b1; req_funct3[D] = 3'b001; req_a[D] = 32'h1234; req_b[D] = 32'h10; req_rd[D] = 5'd5;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_mul_a",     64'(mul_a[D]),     64'(32'd0));
        check_eq("t5_mul_b",     64'(mul_b[D]),     64'(32'd0));
        check_eq("t5_mul_ctrl",  64'(mul_ctrl[D]),  64'(3'b000));
        check_eq("t5_rsp_valid", 64'(rsp_valid[D]), 64'(1'b0));
        check_eq("t5_rsp_data",  64'(rsp_data[D]),  64'(32'd0));
        check_eq("t5_rsp_rd",    64'(rsp_rd[D]),    64'(5'd0));
        check_eq("t5_busy",      64'(busy[D]),      64'(1'b0));
        check_eq("t5_req_ready", 64'(req_ready[D]), 64'(1'b0));
        req_valid[D] = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (rsp_valid[D] === 1'b1) seen = 1'b1;
        end
        check_eq("t5_no_rsp", 64'(seen), 64'(1'b0));

        // ---- randomized traffic on both latencies ----
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0; edges[k] = 0; exp_data[k] = 32'd0; exp_rd[k] = '0;
            last_a[k] = 32'd0; last_b[k] = 32'd0; last_f3[k] = 3'b000;
        end

        for (int c = 0; c < N_RAND; c++) begin
            logic [31:0] pick [2];
            for (int k = 0; k < 2; k++) begin
                int  lat_k;
                logic exp_rv;
                lat_k  = (k == 0) ? 1 : 4;
                exp_rv = pend[k] && (edges[k] >= lat_k);
                check_eq("rnd_rsp_valid", 64'(rsp_valid[k]), 64'(exp_rv));
                if (exp_rv) begin
                    check_eq("rnd_rsp_data",  64'(rsp_data[k]), 64'(exp_data[k]));
                    check_eq("rnd_rsp_rd",    64'(rsp_rd[k]),   64'(exp_rd[k]));
                    check_eq("rnd_rsp_no_x",  64'($isunknown(rsp_data[k])), 64'(1'b0));
                end
                check_eq("rnd_busy",     64'(busy[k]),     64'(pend[k]));
                check_eq("rnd_mul_a",    64'(mul_a[k]),    64'(last_a[k]));
                check_eq("rnd_mul_b",    64'(mul_b[k]),    64'(last_b[k]));
                check_eq("rnd_mul_ctrl", 64'(mul_ctrl[k]), 64'(exp_ctrl(last_f3[k])));

                for (int j = 0; j < 2; j++) begin
                    case ($urandom_range(0, 7))
                        0:       pick[j] = 32'd0;
                        1:       pick[j] = 32'd1;
                        2:       pick[j] = 32'hFFFF_FFFF;
                        3:       pick[j] = 32'h8000_0000;
                        4:       pick[j] = 32'h7FFF_FFFF;
                        default: pick[j] = $urandom;
                    endcase
                end
                req_valid[k]  = ($urandom_range(0, 9) < 7);
                req_funct3[k] = 3'($urandom);
                req_a[k]      = pick[0];
                req_b[k]      = pick[1];
                req_rd[k]     = RD_W'($urandom);
                flush[k]      = ($urandom_range(0, 31) == 0);
                rsp_ready[k]  = ($urandom_range(0, 9) < 7);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                int   lat_k;
                logic exp_rv, exp_rr, acc, hs;
                lat_k  = (k == 0) ? 1 : 4;
                exp_rv = pend[k] && (edges[k] >= lat_k);
                exp_rr = !flush[k] && (!pend[k] || (exp_rv && rsp_ready[k]));
                check_eq("rnd_req_ready", 64'(req_ready[k]), 64'(exp_rr));
                acc = req_valid[k] && exp_rr;
                hs  = exp_rv && rsp_ready[k];
                if (flush[k]) begin
                    pend[k] = 1'b0;
                end else begin
                    if (hs) pend[k] = 1'b0;
                    if (acc) begin
                        pend[k]     = 1'b1;
                        edges[k]    = 0;
                        exp_data[k] = ref_result(req_funct3[k], req_a[k], req_b[k]);
                        exp_rd[k]   = req_rd[k];
                        last_a[k]   = req_a[k];
                        last_b[k]   = req_b[k];
                        last_f3[k]  = req_funct3[k];
                    end else if (pend[k] && edges[k] < lat_k) begin
                        edges[k] = edges[k] + 1;
                    end
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
